// File: rtl/pe_weight_loader_pkg.sv
// Shared types and constants for the PE weight-loader control path.
// Imported by the loader and by any array-level control that walks its states.
package pe_weight_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_PAD   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Value shifted into the chain for kernel rows missing from a sparse group.
  localparam int unsigned PAD_FILL = 0;

  function automatic logic is_busy(input state_e st);
    return st != ST_IDLE;
  endfunction

endpackage

// File: rtl/pe_weight_loader_if.sv
// Sparse weight-entry stream: one nonzero weight plus its feature select and
// column number per valid/ready transfer, with a last flag closing the group.
interface pe_weight_loader_if #(
  parameter int F_WIDTH       = 8,
  parameter int SEL_WIDTH     = 2,
  parameter int NUM_COL_WIDTH = 2
);

  logic                      s_valid_i;
  logic                      s_ready_o;
  logic signed [F_WIDTH-1:0] s_weight_i;
  logic [SEL_WIDTH-1:0]      s_sel_i;
  logic [NUM_COL_WIDTH-1:0]  s_col_i;
  logic                      s_last_i;

  modport master (
    output s_valid_i, s_weight_i, s_sel_i, s_col_i, s_last_i,
    input  s_ready_o
  );

  modport slave (
    input  s_valid_i, s_weight_i, s_sel_i, s_col_i, s_last_i,
    output s_ready_o
  );

endinterface

// File: rtl/pe_weight_loader.sv
// Loads one group of sparse weights into an N-deep PE shift chain: clears the
// chain, shifts accepted entries in, zero-pads short groups, then signals done.
module pe_weight_loader
  import pe_weight_loader_pkg::*;
#(
  parameter int F_WIDTH       = 8,
  parameter int N             = 3,
  parameter int SEL_WIDTH     = $clog2(N),
  parameter int NUM_COL_WIDTH = $clog2(N),
  parameter int CNT_WIDTH     = $clog2(N + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  pe_weight_loader_if.slave         s,
  output logic signed [F_WIDTH-1:0] f_weight_o,
  output logic [SEL_WIDTH-1:0]      f_sel_o,
  output logic [NUM_COL_WIDTH-1:0]  column_num_o,
  output logic                      wreg_wr_en_o,
  output logic                      f_sel_ld_o,
  output logic                      column_num_ld_o,
  output logic                      wreg_rst_o,
  output logic                      f_sel_rst_o,
  output logic                      column_num_rst_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      last_err_o
);

  state_e                    state_q, state_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]      cnt_inc;
  logic                      group_full;
  logic signed [F_WIDTH-1:0] weight_q, weight_d;
  logic [SEL_WIDTH-1:0]      sel_q, sel_d;
  logic [NUM_COL_WIDTH-1:0]  col_q, col_d;
  logic                      shift_q, shift_d;
  logic                      last_err_q, last_err_d;

  // cnt_q counts shifts already issued into the chain this group.
  assign cnt_inc    = cnt_q + CNT_WIDTH'(1);
  assign group_full = (cnt_inc == CNT_WIDTH'(N));

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    weight_d   = weight_q;
    sel_d      = sel_q;
    col_d      = col_q;
    shift_d    = 1'b0;
    last_err_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        cnt_d   = '0;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (s.s_valid_i) begin
          weight_d = s.s_weight_i;
          sel_d    = s.s_sel_i;
          col_d    = s.s_col_i;
          shift_d  = 1'b1;
          cnt_d    = cnt_inc;
          if (group_full) begin
            state_d    = ST_DONE;
            last_err_d = ~s.s_last_i;
          end else if (s.s_last_i) begin
            state_d = ST_PAD;
          end
        end
      end
      ST_PAD: begin
        weight_d = F_WIDTH'(PAD_FILL);
        sel_d    = SEL_WIDTH'(PAD_FILL);
        col_d    = NUM_COL_WIDTH'(PAD_FILL);
        shift_d  = 1'b1;
        cnt_d    = cnt_inc;
        if (group_full) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      weight_q   <= '0;
      sel_q      <= '0;
      col_q      <= '0;
      shift_q    <= 1'b0;
      last_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      weight_q   <= weight_d;
      sel_q      <= sel_d;
      col_q      <= col_d;
      shift_q    <= shift_d;
      last_err_q <= last_err_d;
    end
  end

  // Status and clear strobes decode straight from the state register.
  assign s.s_ready_o      = (state_q == ST_LOAD);
  assign busy_o           = is_busy(state_q);
  assign done_o           = (state_q == ST_DONE);
  assign last_err_o       = last_err_q;
  assign wreg_rst_o       = (state_q == ST_CLEAR);
  assign f_sel_rst_o      = (state_q == ST_CLEAR);
  assign column_num_rst_o = (state_q == ST_CLEAR);

  assign f_weight_o       = weight_q;
  assign f_sel_o          = sel_q;
  assign column_num_o     = col_q;
  assign wreg_wr_en_o     = shift_q;
  assign f_sel_ld_o       = shift_q;
  assign column_num_ld_o  = shift_q;

endmodule

// File: tb/tb_pe_weight_loader.sv
// Directed bench for pe_weight_loader (N=3, 8-bit weights): each scenario is a
// per-cycle table of inputs and the outputs expected just after the next edge.
module tb_pe_weight_loader;

  logic clk_i;
  logic rst_i;
  logic start_i;
  logic signed [7:0] f_weight_o;
  logic [1:0] f_sel_o;
  logic [1:0] column_num_o;
  logic wreg_wr_en_o, f_sel_ld_o, column_num_ld_o;
  logic wreg_rst_o, f_sel_rst_o, column_num_rst_o;
  logic busy_o, done_o, last_err_o;

  int total = 0;
  int bad   = 0;

  pe_weight_loader_if #(.F_WIDTH(8), .SEL_WIDTH(2), .NUM_COL_WIDTH(2)) s_if ();

  pe_weight_loader #(.F_WIDTH(8), .N(3)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .start_i          (start_i),
    .s                (s_if.slave),
    .f_weight_o       (f_weight_o),
    .f_sel_o          (f_sel_o),
    .column_num_o     (column_num_o),
    .wreg_wr_en_o     (wreg_wr_en_o),
    .f_sel_ld_o       (f_sel_ld_o),
    .column_num_ld_o  (column_num_ld_o),
    .wreg_rst_o       (wreg_rst_o),
    .f_sel_rst_o      (f_sel_rst_o),
    .column_num_rst_o (column_num_rst_o),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .last_err_o       (last_err_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // One table row: inputs driven before an edge, outputs expected after it.
  typedef struct {
    logic              rs, st, vl;
    logic signed [7:0] w;
    logic [1:0]        sel, col;
    logic              lst;
    logic [9:0]        ef;
    logic signed [7:0] ew;
    logic [1:0]        es, ec;
  } vec_t;

  // Expected flags: {busy, done, err, ready, shift x3, clear x3}.
  function automatic vec_t row(input int rs, st, vl, w, sel, col, lst,
                               input int bsy, dn, er, rdy, sh, clr,
                               input int ew, es, ec);
    vec_t r;
    r.rs  = 1'(rs);
    r.st  = 1'(st);
    r.vl  = 1'(vl);
    r.w   = 8'(w);
    r.sel = 2'(sel);
    r.col = 2'(col);
    r.lst = 1'(lst);
    r.ef  = {1'(bsy), 1'(dn), 1'(er), 1'(rdy), {3{1'(sh)}}, {3{1'(clr)}}};
    r.ew  = 8'(ew);
    r.es  = 2'(es);
    r.ec  = 2'(ec);
    return r;
  endfunction

  function automatic logic [9:0] obs_flags();
    return {busy_o, done_o, last_err_o, s_if.s_ready_o,
            wreg_wr_en_o, f_sel_ld_o, column_num_ld_o,
            wreg_rst_o, f_sel_rst_o, column_num_rst_o};
  endfunction

  function automatic logic [11:0] obs_data();
    return {f_weight_o, f_sel_o, column_num_o};
  endfunction

  task automatic apply(input vec_t v);
    rst_i           = v.rs;
    start_i         = v.st;
    s_if.s_valid_i  = v.vl;
    s_if.s_weight_i = v.w;
    s_if.s_sel_i    = v.sel;
    s_if.s_col_i    = v.col;
    s_if.s_last_i   = v.lst;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    vec_t v[$];
    v.push_back(row(1,1,1,  5,1,1,1,  0,0,0,0,0,0,  0,0,0));
    v.push_back(row(1,0,0,  0,0,0,0,  0,0,0,0,0,0,  0,0,0));
    v.push_back(row(0,0,0,  0,0,0,0,  0,0,0,0,0,0,  0,0,0));
    foreach (v[i]) begin
      apply(v[i]);
      tick();
      total++;
      if (obs_flags() !== v[i].ef) begin
        bad++;
        $display("FAIL reset[%0d] flags got=%b want=%b", i, obs_flags(), v[i].ef);
      end
      total++;
      if (obs_data() !== {v[i].ew, v[i].es, v[i].ec}) begin
        bad++;
        $display("FAIL reset[%0d] data got=%h want=%h", i, obs_data(), {v[i].ew, v[i].es, v[i].ec});
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[$];
    v.push_back(row(0,1,0,  0,0,0,0,  1,0,0,0,0,1,  0,0,0));
    v.push_back(row(0,0,1,  5,1,0,0,  1,0,0,1,0,0,  0,0,0));
    v.push_back(row(0,0,1,  5,1,0,0,  1,0,0,1,1,0,  5,1,0));
    v.push_back(row(0,0,1, -3,2,1,0,  1,0,0,1,1,0, -3,2,1));
    v.push_back(row(0,0,1,  7,0,2,1,  1,1,0,0,1,0,  7,0,2));
    v.push_back(row(0,0,0,  0,0,0,0,  0,0,0,0,0,0,  7,0,2));
    foreach (v[i]) begin
      apply(v[i]);
      tick();
      total++;
      if (obs_flags() !== v[i].ef) begin
        bad++;
        $display("FAIL b2b[%0d] flags got=%b want=%b", i, obs_flags(), v[i].ef);
      end
      total++;
      if (obs_data() !== {v[i].ew, v[i].es, v[i].ec}) begin
        bad++;
        $display("FAIL b2b[%0d] data got=%h want=%h", i, obs_data(), {v[i].ew, v[i].es, v[i].ec});
      end
    end
  endtask

  task automatic test_pad();
    vec_t v[$];
    v.push_back(row(0,1,0,    0,0,0,0,  1,0,0,0,0,1,     7,0,2));
    v.push_back(row(0,0,1, -128,1,2,1,  1,0,0,1,0,0,     7,0,2));
    v.push_back(row(0,0,1, -128,1,2,1,  1,0,0,0,1,0,  -128,1,2));
    v.push_back(row(0,0,1,    9,1,1,0,  1,0,0,0,1,0,     0,0,0));
    v.push_back(row(0,0,1,    9,1,1,0,  1,1,0,0,1,0,     0,0,0));
    v.push_back(row(0,0,0,    0,0,0,0,  0,0,0,0,0,0,     0,0,0));
    foreach (v[i]) begin
      apply(v[i]);
      tick();
      total++;
      if (obs_flags() !== v[i].ef) begin
        bad++;
        $display("FAIL pad[%0d] flags got=%b want=%b", i, obs_flags(), v[i].ef);
      end
      total++;
      if (obs_data() !== {v[i].ew, v[i].es, v[i].ec}) begin
        bad++;
        $display("FAIL pad[%0d] data got=%h want=%h", i, obs_data(), {v[i].ew, v[i].es, v[i].ec});
      end
    end
  endtask

  task automatic test_missing_last();
    vec_t v[$];
    v.push_back(row(0,1,0,  0,0,0,0,  1,0,0,0,0,1,  0,0,0));
    v.push_back(row(0,0,1,  1,0,0,0,  1,0,0,1,0,0,  0,0,0));
    v.push_back(row(0,0,1,  1,0,0,0,  1,0,0,1,1,0,  1,0,0));
    v.push_back(row(0,0,1,  2,1,1,0,  1,0,0,1,1,0,  2,1,1));
    v.push_back(row(0,0,1,  3,2,2,0,  1,1,1,0,1,0,  3,2,2));
    v.push_back(row(0,0,1,  4,0,1,0,  0,0,0,0,0,0,  3,2,2));
    v.push_back(row(0,0,0,  0,0,0,0,  0,0,0,0,0,0,  3,2,2));
    foreach (v[i]) begin
      apply(v[i]);
      tick();
      total++;
      if (obs_flags() !== v[i].ef) begin
        bad++;
        $display("FAIL nolast[%0d] flags got=%b want=%b", i, obs_flags(), v[i].ef);
      end
      total++;
      if (obs_data() !== {v[i].ew, v[i].es, v[i].ec}) begin
        bad++;
        $display("FAIL nolast[%0d] data got=%h want=%h", i, obs_data(), {v[i].ew, v[i].es, v[i].ec});
      end
    end
  endtask

  task automatic test_gapped();
    vec_t v[$];
    v.push_back(row(0,1,0,    0,0,0,0,  1,0,0,0,0,1,    3,2,2));
    v.push_back(row(0,0,0,   99,3,3,1,  1,0,0,1,0,0,    3,2,2));
    v.push_back(row(0,0,1,   10,1,0,0,  1,0,0,1,1,0,   10,1,0));
    v.push_back(row(0,0,0,   99,3,3,1,  1,0,0,1,0,0,   10,1,0));
    v.push_back(row(0,0,0,   99,3,3,1,  1,0,0,1,0,0,   10,1,0));
    v.push_back(row(0,0,1,  -20,0,1,0,  1,0,0,1,1,0,  -20,0,1));
    v.push_back(row(0,0,1,   30,2,2,1,  1,1,0,0,1,0,   30,2,2));
    v.push_back(row(0,0,0,    0,0,0,0,  0,0,0,0,0,0,   30,2,2));
    foreach (v[i]) begin
      apply(v[i]);
      tick();
      total++;
      if (obs_flags() !== v[i].ef) begin
        bad++;
        $display("FAIL gapped[%0d] flags got=%b want=%b", i, obs_flags(), v[i].ef);
      end
      total++;
      if (obs_data() !== {v[i].ew, v[i].es, v[i].ec}) begin
        bad++;
        $display("FAIL gapped[%0d] data got=%h want=%h", i, obs_data(), {v[i].ew, v[i].es, v[i].ec});
      end
    end
  endtask

  task automatic test_reset_mid_load();
    vec_t v[$];
    v.push_back(row(0,1,0,   0,0,0,0,  1,0,0,0,0,1,  30,2,2));
    v.push_back(row(0,0,1,  11,1,1,0,  1,0,0,1,0,0,  30,2,2));
    v.push_back(row(0,0,1,  11,1,1,0,  1,0,0,1,1,0,  11,1,1));
    v.push_back(row(0,0,1,  12,2,0,0,  1,0,0,1,1,0,  12,2,0));
    v.push_back(row(1,0,1,  13,0,2,1,  0,0,0,0,0,0,   0,0,0));
    v.push_back(row(0,0,0,   0,0,0,0,  0,0,0,0,0,0,   0,0,0));
    v.push_back(row(0,1,0,   0,0,0,0,  1,0,0,0,0,1,   0,0,0));
    v.push_back(row(0,0,1,  14,1,0,0,  1,0,0,1,0,0,   0,0,0));
    v.push_back(row(0,0,1,  14,1,0,0,  1,0,0,1,1,0,  14,1,0));
    v.push_back(row(0,0,1,  15,0,0,1,  1,0,0,0,1,0,  15,0,0));
    v.push_back(row(0,0,0,   0,0,0,0,  1,1,0,0,1,0,   0,0,0));
    v.push_back(row(0,0,0,   0,0,0,0,  0,0,0,0,0,0,   0,0,0));
    foreach (v[i]) begin
      apply(v[i]);
      tick();
      total++;
      if (obs_flags() !== v[i].ef) begin
        bad++;
        $display("FAIL rstmid[%0d] flags got=%b want=%b", i, obs_flags(), v[i].ef);
      end
      total++;
      if (obs_data() !== {v[i].ew, v[i].es, v[i].ec}) begin
        bad++;
        $display("FAIL rstmid[%0d] data got=%h want=%h", i, obs_data(), {v[i].ew, v[i].es, v[i].ec});
      end
    end
  endtask

  task automatic test_start_held();
    vec_t v[$];
    v.push_back(row(0,1,0,  0,0,0,0,  1,0,0,0,0,1,  0,0,0));
    v.push_back(row(0,1,1,  1,1,1,0,  1,0,0,1,0,0,  0,0,0));
    v.push_back(row(0,1,1,  1,1,1,0,  1,0,0,1,1,0,  1,1,1));
    v.push_back(row(0,1,1,  2,2,2,1,  1,0,0,0,1,0,  2,2,2));
    v.push_back(row(0,1,0,  0,0,0,0,  1,1,0,0,1,0,  0,0,0));
    v.push_back(row(0,1,0,  0,0,0,0,  0,0,0,0,0,0,  0,0,0));
    v.push_back(row(0,1,0,  0,0,0,0,  1,0,0,0,0,1,  0,0,0));
    v.push_back(row(0,0,0,  0,0,0,0,  1,0,0,1,0,0,  0,0,0));
    v.push_back(row(1,0,0,  0,0,0,0,  0,0,0,0,0,0,  0,0,0));
    foreach (v[i]) begin
      apply(v[i]);
      tick();
      total++;
      if (obs_flags() !== v[i].ef) begin
        bad++;
        $display("FAIL starthold[%0d] flags got=%b want=%b", i, obs_flags(), v[i].ef);
      end
      total++;
      if (obs_data() !== {v[i].ew, v[i].es, v[i].ec}) begin
        bad++;
        $display("FAIL starthold[%0d] data got=%h want=%h", i, obs_data(), {v[i].ew, v[i].es, v[i].ec});
      end
    end
  endtask

  initial begin
    rst_i           = 1'b1;
    start_i         = 1'b0;
    s_if.s_valid_i  = 1'b0;
    s_if.s_weight_i = '0;
    s_if.s_sel_i    = '0;
    s_if.s_col_i    = '0;
    s_if.s_last_i   = 1'b0;

    test_reset();
    test_back_to_back();
    test_pad();
    test_missing_last();
    test_gapped();
    test_reset_mid_load();
    test_start_held();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
